// File: rtl/phase_sequencer.sv
// Run-control sequencer: free-running cycle counter plus a go/done run of
// NUM_PHASES x PHASE_CYCLES cycles. Optional watchdog: PHASE_SEQUENCER_WATCHDOG_EN.
module phase_sequencer #(
  parameter int WIDTH        = 32,
  parameter int NUM_PHASES   = 4,
  parameter int PHASE_CYCLES = 10,
  parameter int PHASE_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  parameter int WD_LIMIT     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               go_i,
  input  logic               pause_i,
  output logic [WIDTH-1:0]   ctr_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phase_tick_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               wd_err_o
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PH_LAST  = PHASE_W'(NUM_PHASES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   ctr_q, ctr_d;
  logic [PHASE_W-1:0] phase_q;
  logic               tick_q, busy_q, done_q;
  logic               wd_trip;

  assign ctr_d = ctr_q + WIDTH'(1);

`ifdef PHASE_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

  logic [WD_W-1:0] wd_q;
  logic            wd_err_q;

  // Trips on the edge that would make the paused-run count reach WD_LIMIT.
  assign wd_trip = (state_q == S_RUN) && pause_i && (wd_q == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q     <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_q <= ((state_q == S_RUN) && pause_i && !wd_trip) ? wd_q + WD_W'(1) : '0;
      if (wd_trip) wd_err_q <= 1'b1;
    end
  end

  assign wd_err_o = wd_err_q;
`else
  assign wd_trip  = 1'b0;
  assign wd_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            phase_q <= '0;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (wd_trip) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!pause_i) begin
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q  <= '0;
              tick_q <= 1'b1;
              if (phase_q != PH_LAST) begin
                phase_q <= phase_q + PHASE_W'(1);
              end else begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          // Four-phase handshake: go must drop before another run.
          if (!go_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            phase_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctr_o        = ctr_q;
  assign phase_o      = phase_q;
  assign phase_tick_o = tick_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
